// File: rtl/bit_serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and the default operand width.
package bit_serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : bit_serial_sub_pkg

// File: rtl/bit_serial_sub_fs_cell.sv
// One-bit full subtractor: computes a - b - bin for a single bit position.
module fs_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    // Difference bit and borrow-out; purely combinational.
    always_comb begin
        d_o    = a_i ^ b_i ^ bin_i;
        bout_o = (~a_i & b_i) | (~a_i & bin_i) | (b_i & bin_i);
    end

endmodule : fs_cell

// File: rtl/bit_serial_sub.sv
// Bit-serial unsigned subtractor. Operands are captured on acceptance and
// processed LSB first through a single full-subtractor cell, one bit per
// cycle, with a borrow flop carrying the borrow between bit positions.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE
// and diff/bout stay stable while out_valid && !out_ready. Neither side's
// ready may depend combinationally on the other side's valid.
module bit_serial_sub
    import bit_serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output state_e           dbg_state_o
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   diff_q;
    logic [CW-1:0]      cnt_q;
    logic               borrow_q;
    logic               bout_q;
    logic               out_valid_q;

    logic               cell_diff;
    logic               cell_borrow;

    // The borrow flop is the only feedback around the cell.
    fs_cell u_fs_cell (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .bin_i  (borrow_q),
        .d_o    (cell_diff),
        .bout_o (cell_borrow)
    );

    // Control FSM and datapath registers. DONE spends one cycle raising the
    // registered out_valid before it can be consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            diff_q      <= '0;
            cnt_q       <= '0;
            borrow_q    <= 1'b0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        borrow_q <= bin;
                        cnt_q    <= '0;
                        diff_q   <= '0;
                        bout_q   <= 1'b0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    diff_q   <= {cell_diff, diff_q[WIDTH-1:1]};
                    borrow_q <= cell_borrow;
                    if (cnt_q == CNT_LAST) begin
                        bout_q  <= cell_borrow;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Output decode; in_ready follows state, everything else is registered.
    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid   = out_valid_q;
        diff        = diff_q;
        bout        = bout_q;
        dbg_state_o = state_q;
    end

endmodule : bit_serial_sub
